// File: rtl/basic_homework2_if.sv
// Bus bundle for the registered 4-to-1 mux: four data words, select,
// enable, and the registered result.
// Optional parity output is present when BASIC_HOMEWORK2_PARITY_EN is defined.
interface basic_homework2_if #(
    parameter int WIDTH = 2
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] C;
    logic [WIDTH-1:0] D;
    logic [1:0]       S;
    logic             EN;
    logic [WIDTH-1:0] Y;
    logic             VLD;
`ifdef BASIC_HOMEWORK2_PARITY_EN
    logic             YP;
`endif

    // Producer side: drives data/select/enable, observes the registered result.
    modport master (
        output A, B, C, D, S, EN,
`ifdef BASIC_HOMEWORK2_PARITY_EN
        input  YP,
`endif
        input  Y, VLD
    );

    // Mux side: consumes data/select/enable, drives the registered result.
    modport slave (
        input  A, B, C, D, S, EN,
`ifdef BASIC_HOMEWORK2_PARITY_EN
        output YP,
`endif
        output Y, VLD
    );
endinterface

// File: rtl/basic_homework2.sv
// Registered 4-to-1 multiplexer with output enable.
// One-cycle latency from A..D/S/EN to Y/VLD; EN low zeroes Y rather than
// holding it. Unsigned pass-through, no extension.
// Optional feature macro: BASIC_HOMEWORK2_PARITY_EN adds YP, the even
// parity of the word loaded into Y on the same edge.
module basic_homework2 #(
    parameter int WIDTH = 2
) (
    input logic                clk,
    input logic                rst,
    basic_homework2_if.slave   bus
);

    // Select one of the four data words by the 2-bit code.
    function automatic logic [WIDTH-1:0] mux4(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] c,
        input logic [WIDTH-1:0] d,
        input logic [1:0]       s
    );
        logic [WIDTH-1:0] r;
        case (s)
            2'b00:   r = a;
            2'b01:   r = b;
            2'b10:   r = c;
            default: r = d;
        endcase
        return r;
    endfunction

    logic [WIDTH-1:0] w_y_p0;
    logic             w_vld_p0;
    logic [WIDTH-1:0] r_y_p1;
    logic             r_vld_p1;

    // Stage 0: combinational select, forced to zero when not enabled.
    always_comb begin
        w_vld_p0 = bus.EN;
        w_y_p0   = '0;
        if (bus.EN) begin
            w_y_p0 = mux4(bus.A, bus.B, bus.C, bus.D, bus.S);
        end
    end

    // Stage 1: output register; reset wins over enable and select.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y_p1   <= '0;
            r_vld_p1 <= 1'b0;
        end else begin
            r_y_p1   <= w_y_p0;
            r_vld_p1 <= w_vld_p0;
        end
    end

    assign bus.Y   = r_y_p1;
    assign bus.VLD = r_vld_p1;

`ifdef BASIC_HOMEWORK2_PARITY_EN
    logic r_yp_p1;

    // Stage 1: parity of the next Y, so YP always matches the Y it travels with.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_yp_p1 <= 1'b0;
        end else begin
            r_yp_p1 <= ^w_y_p0;
        end
    end

    assign bus.YP = r_yp_p1;
`endif

endmodule

// File: tb/tb_basic_homework2.sv
// Directed, table-driven bench for basic_homework2 at WIDTH=2.
// Parity checks are active when BASIC_HOMEWORK2_PARITY_EN is defined.
module tb_basic_homework2;

    localparam int W = 2;

    typedef struct {
        logic         rst;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
        logic [W-1:0] d;
        logic [1:0]   s;
        logic         en;
        logic [W-1:0] exp_y;
        logic         exp_vld;
        logic         exp_yp;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    vec_t vecs[17];

    basic_homework2_if #(.WIDTH(W)) bus();

    basic_homework2 #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic [W-1:0] d,
                         input logic [1:0] s, input logic en);
        rst    = r;
        bus.A  = a;
        bus.B  = b;
        bus.C  = c;
        bus.D  = d;
        bus.S  = s;
        bus.EN = en;
    endtask

    task automatic check_out(input string tag, input logic [W-1:0] ey, input logic ev, input logic ep);
        check({tag, ".Y"},   64'(bus.Y),   64'(ey));
        check({tag, ".VLD"}, 64'(bus.VLD), 64'(ev));
`ifdef BASIC_HOMEWORK2_PARITY_EN
        check({tag, ".YP"},  64'(bus.YP),  64'(ep));
`else
        if (ep !== ep) check({tag, ".YP"}, 64'(0), 64'(1));
`endif
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        //          rst   A     B     C     D     S     EN    Y     VLD   YP
        vecs[0]  = '{1'b1, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 1'b1, 2'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 1'b1, 2'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 1'b1, 2'd3, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 1'b1, 2'd0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 1'b1, 2'd1, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 1'b1, 2'd2, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 1'b1, 2'd3, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 1'b1, 2'd2, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 1'b1, 2'd1, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 2'd3, 2'd1, 2'd0, 2'd0, 2'd1, 1'b1, 2'd1, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 2'd0, 2'd2, 2'd2, 2'd3, 2'd1, 1'b1, 2'd2, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 1'b1, 2'd3, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 1'b1, 2'd0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 1'b1, 2'd3, 1'b1, 1'b0};
        vecs[15] = '{1'b1, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd0, 1'b1, 2'd1, 1'b1, 1'b1};

        drive(1'b1, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 1'b1);

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, vecs[i].s, vecs[i].en);
            @(posedge clk);
            #1;
            check_out($sformatf("vec%0d", i), vecs[i].exp_y, vecs[i].exp_vld, vecs[i].exp_yp);
        end

        // Between-edge change of the selected input must not reach Y early.
        @(negedge clk);
        drive(1'b0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 1'b1);
        @(posedge clk);
        #1;
        check_out("hold_pre", 2'd1, 1'b1, 1'b1);
        @(negedge clk);
        bus.B = 2'd2;
        #1;
        check_out("hold_mid", 2'd1, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        check_out("hold_post", 2'd2, 1'b1, 1'b1);

        // Dropping EN between edges leaves outputs alone until the edge.
        @(negedge clk);
        bus.EN = 1'b0;
        #1;
        check_out("en_mid", 2'd2, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        check_out("en_post", 2'd0, 1'b0, 1'b0);

        // Asserting rst between edges clears nothing until the edge.
        @(negedge clk);
        drive(1'b0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 1'b1);
        @(posedge clk);
        #1;
        check_out("rst_pre", 2'd3, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_out("rst_mid", 2'd3, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check_out("rst_post", 2'd0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/basic_homework2.md
Name: basic_homework2

Overview:
- Registered 4-to-1 multiplexer with an output enable.
- Selects one of four WIDTH-bit data words (A/B/C/D) by a 2-bit select S. Presents the chosen word on Y after one clock edge.
- Small datapath steering element; sits between data sources and a single consumer bus. No handshake; the consumer samples Y every cycle.

Parameters:
- WIDTH, 2, bit width of each data input and of Y (legal range 1..64).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- A  input  WIDTH  data word selected when S=2'b00.
- B  input  WIDTH  data word selected when S=2'b01.
- C  input  WIDTH  data word selected when S=2'b10.
- D  input  WIDTH  data word selected when S=2'b11.
- S  input  2  select code.
- EN  input  1  enable, active-high; when low, the output is forced to zero.
- Y  output  WIDTH  registered selected word.
- VLD  output  1  registered copy of EN, qualifying Y.

Interface note: one clock; reset is synchronous and active-high (ports clk and rst).

Behaviour:
- Reset:
  - On a rising clk edge with rst=1: Y <= 0 and VLD <= 0.
  - rst has priority over EN and S.
  - Mid-operation reset clears the outputs on that same edge, with no residual data.
- Normal operation, on each rising edge with rst=0:
  - If EN=1: Y <= S==00 ? A : S==01 ? B : S==10 ? C : D; VLD <= 1.
  - If EN=0: Y <= 0; VLD <= 0 (output zeroed, not held).
- Latency: exactly 1 cycle from inputs (A–D, S, EN) to Y/VLD. No combinational path from any input to any output.
- Data inputs that are not selected have no effect.
- A change to a data input or to S between edges is seen only at the next edge. The value sampled at the edge wins.
- S or data containing X/Z is not supported. The implementation need not define the result.
- Y is an unsigned pass-through: no arithmetic, no sign or width extension. All four inputs and Y are exactly WIDTH bits.
- Power-up value before the first reset: don't-care. Benches must apply rst for at least 1 cycle.

Optional Feature:
- Macro: BASIC_HOMEWORK2_PARITY_EN.
- When defined:
  - Adds output port YP (1 bit).
  - YP is registered with Y on the same edge: YP <= ^(next Y), i.e. even parity of the word loaded into Y.
  - Reset value of YP is 0.
  - With EN=0, YP <= 0.
- When undefined:
  - Port YP does not exist.
  - No parity logic is generated.
  - All other behaviour is identical.

Test Plan:
- rst=1 for 2 cycles with A=00, B=01, C=10, D=11, EN=1, S=11 -> Y=00, VLD=0 throughout reset. First edge after rst drops -> Y=11, VLD=1.
- A=00, B=01, C=10, D=11, EN=1, S stepped 00,01,10,11 on consecutive edges -> Y=00,01,10,11 respectively, each one cycle after its S is applied; VLD=1.
- Same data, S=10, EN=0 -> Y=00, VLD=0. Raise EN=1 -> next edge Y=10, VLD=1.
- EN=1, S=01, B changes 01->10 between edges -> Y shows 10 only after the next rising edge. Changing A/C/D alone leaves Y unchanged.
- Mid-operation: EN=1, S=11, Y=11, then rst=1 for 1 cycle -> Y=00 and VLD=0 on that edge. After release, Y returns to 11 one cycle later.
- With BASIC_HOMEWORK2_PARITY_EN and WIDTH=2:
  - S=00 -> YP=0.
  - S=01 -> YP=1.
  - S=10 -> YP=1.
  - S=11 -> YP=0.
  - EN=0 -> YP=0.
